credit_arbiter: RTL

- Shares one credit-controlled downstream link between N_REQ upstream pearls. Each pearl presents a FIFO-empty flag.
- Grants one transfer per cycle in round-robin order. A grant is issued only while the shared credit pool is non-zero.
- Sits between the per-pearl output FIFOs and the single link to the downstream relay/consumer. It replaces one credit counter per pearl with one pooled counter.
- Supports a flush/drain sequence that waits for all outstanding credits to return.

---
 rtl/credit_arb_pkg.sv | 27 ++
 rtl/credit_arbiter_rr.sv | 43 ++++
 rtl/credit_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/credit_arb_pkg.sv
// ============================================================================
// Module      : credit_arb_pkg
// Description : Shared types and helpers for the pooled-credit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package credit_arb_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Width of each statistics counter
  localparam int STAT_W = 16;

  // Counter wide enough to hold the value n itself (0..n)
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/credit_arbiter_rr.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Searches the request
//               vector starting at ptr, wrapping modulo N_REQ; the first
//               pending requester wins. The pointer register lives in the
//               parent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import credit_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Rotating priority search: first pending requester at or after ptr
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/credit_arbiter.sv
// ============================================================================
// Module      : credit_arbiter
// Description : Round-robin arbiter sharing one pooled credit counter for a
//               single downstream link. One grant per cycle while credits
//               remain; flush drains the pool until all credits return.
//               Optional statistics enabled by macro CREDIT_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module credit_arbiter
  import credit_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int N_CREDITS = 10,
  localparam int IDX_W     = $clog2(N_REQ),
  localparam int CNT_W     = cnt_width(N_CREDITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_fifo_empty,
  input  logic             i_credit_return,
  input  logic             i_flush,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_credit_count,
  output logic             o_flush_done,
  output logic             o_err
`ifdef CREDIT_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] o_grant_cnt,
  output logic [STAT_W-1:0]       o_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] FULL     = CNT_W'(N_CREDITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] ptr;
  logic             err;
  logic             flush_done;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic             grant_en;

  assign req = ~i_fifo_empty;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // A transfer may go out only when running, with credit, and with a request
  assign grant_en = (state == RUN) && (count != '0) && arb_any;

  assign o_valid        = grant_en;
  assign o_grant        = grant_en ? arb_grant : '0;
  assign o_grant_idx    = grant_en ? arb_idx   : '0;
  assign o_credit_count = count;
  assign o_flush_done   = flush_done;
  assign o_err          = err;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush_done marks the cycle that leaves DRAIN
  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      INIT: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (i_flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (count == FULL) begin
          state_nxt  = RUN;
          flush_done = 1'b1;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // Credit pool, sticky overflow flag and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= FULL;
      err   <= 1'b0;
      ptr   <= '0;
    end else begin
      if (grant_en && !i_credit_return) begin
        count <= count - 1'b1;
      end else if (!grant_en && i_credit_return) begin
        // A return into a full pool is a downstream protocol error
        if (count == FULL) begin
          err <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
      if (grant_en) begin
        ptr <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
      end
    end
  end

`ifdef CREDIT_ARB_STATS_EN
  logic [STAT_W-1:0] stall_cnt;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant_stat
      logic [STAT_W-1:0] gcnt;

      // Per-requester saturating grant counter
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          gcnt <= '0;
        end else if (grant_en && arb_grant[gi] && (gcnt != '1)) begin
          gcnt <= gcnt + 1'b1;
        end
      end

      assign o_grant_cnt[gi*STAT_W +: STAT_W] = gcnt;
    end
  endgenerate

  // Saturating count of cycles starved of credit while work is waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && arb_any && (count == '0) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt;
`endif

endmodule

`default_nettype wire
